// File: rtl/adder_seq_ctrl.sv
// Serial adder controller: streams two WIDTH-bit operands through one shared
// 2-bit ripple slice, low pair first, and registers {Cout, Sum} at the end.
module adder_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [1:0]       dbg_state
);

    localparam int PAIRS = WIDTH / 2;
    localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(PAIRS - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
        $error("adder_seq_ctrl: WIDTH must be even and at least 2");
    end

    // Handshake: Start is sampled only while Busy=0; a sampled Start captures
    // A/B/Cin and raises Busy on the next cycle. Done pulses for one cycle with
    // Busy still high, when Sum/Cout are valid; Start while Busy is dropped.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_pair;
    logic             s0;
    logic             c0;
    logic             s1;
    logic             c1;

    // Shared 2-bit ripple slice.
    always_comb begin
        s0 = a_sh[0] ^ b_sh[0] ^ carry;
        c0 = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        s1 = a_sh[1] ^ b_sh[1] ^ c0;
        c1 = (a_sh[1] & b_sh[1]) | (a_sh[1] & c0) | (b_sh[1] & c0);
        // New pair enters at the top; works for WIDTH=2 where acc is fully replaced.
        acc_next  = WIDTH'({s1, s0, acc} >> 2);
        last_pair = (cnt == LAST_CNT);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (last_pair) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 2;
                    b_sh  <= b_sh >> 2;
                    acc   <= acc_next;
                    carry <= c1;
                    // Counter parks on the last pair rather than wrapping.
                    if (!last_pair) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (last_pair) begin
                        Sum  <= acc_next;
                        Cout <= c1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy      = (state != IDLE);
    assign Done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: WIDTH=8 instance against a cycle-level behavioural
// model, plus exhaustive WIDTH=4 and WIDTH=2 instances.
module tb_adder_seq_ctrl;

    localparam int W = 8;
    localparam int P = W / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, start = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic [1:0]   dbg;

    logic       rst4 = 1'b1, start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       busy4, done4, cout4;
    logic [1:0] dbg4;

    logic       rst2 = 1'b1, start2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0, sum2;
    logic       busy2, done2, cout2;
    logic [1:0] dbg2;

    adder_seq_ctrl #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST(rst), .Start(start), .A(a), .B(b), .Cin(cin),
        .Busy(busy), .Done(done), .Sum(sum), .Cout(cout), .dbg_state(dbg)
    );
    adder_seq_ctrl #(.WIDTH(4)) u_dut4 (
        .CLK(clk), .RST(rst4), .Start(start4), .A(a4), .B(b4), .Cin(cin4),
        .Busy(busy4), .Done(done4), .Sum(sum4), .Cout(cout4), .dbg_state(dbg4)
    );
    adder_seq_ctrl #(.WIDTH(2)) u_dut2 (
        .CLK(clk), .RST(rst2), .Start(start2), .A(a2), .B(b2), .Cin(cin2),
        .Busy(busy2), .Done(done2), .Sum(sum2), .Cout(cout2), .dbg_state(dbg2)
    );

    int tests = 0;
    int fails = 0;
    bit fin4 = 1'b0;
    bit fin2 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: phase counts cycles since acceptance; the result is
    // plain A+B+Cin queued at accept and published when the run completes.
    int           m_phase = 0;
    logic [W:0]   exp_q[$];
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            exp_q.delete();
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
                m_phase = 1;
            end
        end else if (m_phase == P) begin
            {m_cout, m_sum} = exp_q.pop_front();
            m_phase = P + 1;
        end else if (m_phase == P + 1) begin
            m_phase = 0;
        end else begin
            m_phase++;
        end
    end

    always @(posedge clk) begin
        #1;
        check("busy", busy, (m_phase != 0));
        check("done", done, (m_phase == P + 1));
        check("sum", sum, m_sum);
        check("cout", cout, m_cout);
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic [W-1:0] es, input logic ec, input bit noisy,
                         input string name);
        int lat;
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) begin
                a = W'($urandom);
                b = W'($urandom);
            end
        end while (!done && lat < 20);
        start = 1'b0;
        check({name, "_done"}, done, 1);
        check({name, "_lat"}, lat, P + 1);
        check({name, "_sum"}, sum, es);
        check({name, "_cout"}, cout, ec);
    endtask

    initial begin
        int n;
        int saw;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   rs;

        start = 1'b1; a = 8'h5A; b = 8'h3C;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_no_start", busy, 0);

        do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, "basic");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "chain1");
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "chain2");

        // Start held high; operand change during Busy must be ignored.
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'h10; b = 8'h20;
        n = 1;
        while (!done && n < 20) begin @(negedge clk); n++; end
        check("held1_done", done, 1);
        check("held1_sum", sum, 8'h02);
        @(negedge clk);
        check("held_idle", busy, 0);
        @(negedge clk);
        check("held_busy2", busy, 1);
        check("held_sum_hold", sum, 8'h02);
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        start = 1'b0;
        check("held2_done", done, 1);
        check("held2_sum", sum, 8'h30);

        // Reset in the third RUN cycle aborts without a Done pulse.
        @(negedge clk);
        @(negedge clk);
        a = 8'h80; b = 8'h80; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 8'h00);
        check("abort_cout", cout, 0);
        rst = 1'b0;
        saw = 0;
        repeat (8) begin @(negedge clk); if (done) saw++; end
        check("abort_no_done", saw, 0);
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, "after_abort");

        repeat (150) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(ra, rb, rc, rs[W-1:0], rs[W], 1'b1, "rand");
        end

        n = 0;
        while (!(fin4 && fin2) && n < 20000) begin @(negedge clk); n++; end
        check("small_builds_finished", {30'd0, fin4, fin2}, 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        rst4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    a4 = 4'(i); b4 = 4'(j); cin4 = 1'(c); start4 = 1'b1;
                    @(posedge clk);
                    lat = 0;
                    do begin
                        @(negedge clk);
                        lat++;
                        start4 = 1'b0;
                    end while (!done4 && lat < 10);
                    check("w4_done", done4, 1);
                    check("w4_lat", lat, 3);
                    check("w4_result", {cout4, sum4}, i + j + c);
                end
            end
        end
        fin4 = 1'b1;
    end

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    a2 = 2'(i); b2 = 2'(j); cin2 = 1'(c); start2 = 1'b1;
                    @(posedge clk);
                    lat = 0;
                    do begin
                        @(negedge clk);
                        lat++;
                        start2 = 1'b0;
                    end while (!done2 && lat < 10);
                    check("w2_done", done2, 1);
                    check("w2_lat", lat, 2);
                    check("w2_result", {cout2, sum2}, i + j + c);
                end
            end
        end
        fin2 = 1'b1;
    end

endmodule
